// File: rtl/regist_pkg.sv
// Shared types and constants for the position-register driver.
package regist_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HOME_HI,
      HOME_LO,
      STEP_HI,
      STEP_LO,
      FIN
   } state_t;

   typedef logic [1:0] pos_t;

   localparam int unsigned NUM_POS = 4;
   localparam int unsigned CNT_W   = 4;

   // One step toward the end of the range, holding at either end.
   function automatic pos_t step_pos(input pos_t p, input logic up);
      if (up) begin
         return (p == pos_t'(NUM_POS - 1)) ? p : p + pos_t'(1);
      end
      return (p == pos_t'(0)) ? p : p - pos_t'(1);
   endfunction

endpackage

// File: rtl/pulse_timer.sv
// Phase timer: load a cycle count, count down, flag when the phase has run out.
module pulse_timer
   import regist_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/regist_driver.sv
// Drives left/right/first_pos pulses to walk a 4-position register to a requested target.
// Optional boot-time homing: define REGIST_DRIVER_AUTO_HOME_EN.
module regist_driver
   import regist_pkg::*;
#(
   parameter int unsigned HI_CYCLES  = 1,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic [1:0] req_target,
   output logic       req_ready,
   output logic       left,
   output logic       right,
   output logic       first_pos,
   output logic       done,
   output logic [1:0] pos,
   output logic       pos_valid
);

   // Timer is loaded with N-1 so the phase lasts exactly N cycles.
   localparam logic [CNT_W-1:0] HI_LOAD  = CNT_W'(HI_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

   state_t           state_q, state_d;
   pos_t             pos_q, pos_d;
   pos_t             target_q, target_d;
   logic             valid_q, valid_d;
   logic             auto_q, auto_d;
   logic             boot;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_exp;

`ifdef REGIST_DRIVER_AUTO_HOME_EN
   // High only in the first cycle after reset is released.
   logic boot_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         boot_q <= 1'b1;
      end else begin
         boot_q <= 1'b0;
      end
   end

   assign boot = boot_q & ~rst;
`else
   assign boot = 1'b0;
`endif

   pulse_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_exp)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         pos_q    <= '0;
         target_q <= '0;
         valid_q  <= 1'b0;
         auto_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         target_q <= target_d;
         valid_q  <= valid_d;
         auto_q   <= auto_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      target_d  = target_q;
      valid_d   = valid_q;
      auto_d    = auto_q;
      tmr_load  = 1'b0;
      tmr_val   = HI_LOAD;
      req_ready = 1'b0;
      left      = 1'b0;
      right     = 1'b0;
      first_pos = 1'b0;
      done      = 1'b0;

      unique case (state_q)
         IDLE: begin
            req_ready = ~boot;
            if (boot) begin
               state_d  = HOME_HI;
               auto_d   = 1'b1;
               tmr_load = 1'b1;
            end else if (req_valid) begin
               target_d = req_target;
               auto_d   = 1'b0;
               if (!valid_q) begin
                  state_d  = HOME_HI;
                  tmr_load = 1'b1;
               end else if (req_target != pos_q) begin
                  state_d  = STEP_HI;
                  tmr_load = 1'b1;
               end else begin
                  state_d = FIN;
               end
            end
         end

         HOME_HI: begin
            first_pos = 1'b1;
            if (tmr_exp) begin
               state_d  = HOME_LO;
               tmr_load = 1'b1;
               tmr_val  = GAP_LOAD;
            end
         end

         HOME_LO: begin
            if (tmr_exp) begin
               pos_d   = '0;
               valid_d = 1'b1;
               // The boot-time run ends silently; a requested one continues the move.
               if (auto_q) begin
                  state_d = IDLE;
               end else if (target_q != pos_t'(0)) begin
                  state_d  = STEP_HI;
                  tmr_load = 1'b1;
               end else begin
                  state_d = FIN;
               end
            end
         end

         STEP_HI: begin
            right = (target_q > pos_q);
            left  = (target_q < pos_q);
            if (tmr_exp) begin
               state_d  = STEP_LO;
               tmr_load = 1'b1;
               tmr_val  = GAP_LOAD;
            end
         end

         STEP_LO: begin
            if (tmr_exp) begin
               pos_d = step_pos(pos_q, target_q > pos_q);
               if (pos_d == target_q) begin
                  state_d = FIN;
               end else begin
                  state_d  = STEP_HI;
                  tmr_load = 1'b1;
               end
            end
         end

         FIN: begin
            done    = 1'b1;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign pos       = pos_q;
   assign pos_valid = valid_q;

endmodule

// File: doc/regist_driver.md
REGIST_DRIVER -- requirements
Module: regist_driver

Interface
REQ-001 Parameter: HI_CYCLES, default 1, high-time in clocks of every output pulse (range 1..15).
REQ-002 Parameter: GAP_CYCLES, default 1, minimum low-time in clocks after every output pulse (range 1..15).
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: req_valid  input  1  move request present.
REQ-006 Port: req_target  input  2  target position; 0..3 map to SET1..SET4.
REQ-007 Port: req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready.
REQ-008 Port: left  output  1  step-left pulse to position register.
REQ-009 Port: right  output  1  step-right pulse to position register.
REQ-010 Port: first_pos  output  1  home pulse; forces position register to SET1.
REQ-011 Port: done  output  1  one-cycle pulse when a move completes.
REQ-012 Port: pos  output  2  modelled current position of the register.
REQ-013 Port: pos_valid  output  1  pos is known; cleared by reset, set by a home pulse.

Function
REQ-014 States SHALL be IDLE, HOME_HI, HOME_LO, STEP_HI, STEP_LO, FIN.
REQ-015 IDLE + accept with pos_valid=0 -> HOME_HI; with pos_valid=1 and target!=pos -> STEP_HI; with target==pos -> FIN.
REQ-016 HOME_HI: first_pos=1 for HI_CYCLES, then HOME_LO for GAP_CYCLES; on leaving HOME_LO pos=0, pos_valid=1, then STEP_HI if target!=0 else FIN.
REQ-017 STEP_HI: right=1 if target>pos, else left=1, for HI_CYCLES; then STEP_LO for GAP_CYCLES; pos +/-1 on leaving STEP_LO; repeat STEP_HI until pos==target, then FIN.
REQ-018 FIN: done=1 for exactly one cycle, then IDLE.
REQ-019 At most one of left/right/first_pos SHALL be high in any cycle; every pulse SHALL be followed by >= GAP_CYCLES low cycles.
REQ-020 Latency: accept at cycle t; first pulse high at t+1; done at t+1+(H+N)*(HI_CYCLES+GAP_CYCLES), N=|target-pos|, H=1 if homing else 0.
REQ-021 pos SHALL saturate within 0..3; no wrap-around; the direction is always toward target.
REQ-022 req_valid while not IDLE SHALL be ignored (req_ready=0); req_target latched at accept only.
REQ-023 pos/pos_valid update only on completed pulse-plus-gap periods.

Reset
REQ-024 rst=1 at any edge, including mid-pulse: next cycle state=IDLE, left=right=first_pos=done=0, pos=0, pos_valid=0, req_ready=1.
REQ-025 rst held high SHALL keep all outputs at reset values; no pulse truncation glitch beyond that edge.

Configuration
REQ-026 Macro REGIST_DRIVER_AUTO_HOME_EN: when defined, after rst deasserts the block enters HOME_HI unrequested, issues one first_pos pulse, sets pos_valid=1, returns to IDLE without done; req_ready=0 during this sequence.
REQ-027 Without REGIST_DRIVER_AUTO_HOME_EN: homing occurs only as part of the first accepted request (REQ-015).

Structure
REQ-028 Package regist_pkg SHALL hold: state enum type, pos_t (2-bit), NUM_POS=4, counter width constant CNT_W=4.
REQ-029 Sub-module pulse_timer SHALL count HI/GAP phases (load, count-down, expire flag); regist_driver instantiates one.

Verification
REQ-030 Reset then request target=2, defaults, macro off -> first_pos high at t+1, right pulses at t+3, t+5, done at t+7, pos=2.
REQ-031 From pos=2, request target=0 -> two left pulses 2 cycles apart, done at t+5, pos=0, no right/first_pos activity.
REQ-032 From pos=1, request target=1 -> no pulses, done at t+1, req_ready low only at t+1.
REQ-033 HI_CYCLES=3, GAP_CYCLES=2, from pos=0 to 3 -> right high 3 cycles, low 2, three times; done at t+16.
REQ-034 Assert rst during second right pulse of a 0->3 move -> right low next cycle, pos_valid=0; next request homes first.
REQ-035 Macro defined: after reset release, one first_pos pulse with no request, no done, pos_valid=1, then req_ready=1.
